fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: width of PC, addresses and instructions.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port pc_src, input, 2: 00 sequential, 01 branch, 10 jump, 11 treated as 00.
REQ-007 Port branch_adr, input, XLEN: branch target, sampled when pc_src=01.
REQ-008 Port jump_adr, input, XLEN: jump target, sampled when pc_src=10.
REQ-009 Port imem_rd, output, 1: instruction-memory read request this cycle.
REQ-010 Port imem_addr, output, XLEN: read address; equals the current PC.
REQ-011 Port imem_data, input, XLEN: read data, valid exactly 1 cycle after imem_rd.
REQ-012 Port out_valid, output, 1: queue head holds a valid instruction.
REQ-013 Port out_ready, input, 1: decode accepts the head this cycle.
REQ-014 Port out_instr, output, XLEN: head instruction.
REQ-015 Port out_pc4, output, XLEN: head instruction's PC + 4.

Function
REQ-016 Redirect = (pc_src==01 or pc_src==10); target = branch_adr or jump_adr respectively.
REQ-017 Issue condition: imem_rd=1 when no redirect, not rst, and (count + inflight) < DEPTH.
REQ-018 On issue without redirect, PC <= PC + 4, modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
REQ-019 inflight is 1 for the cycle after an issue and 0 otherwise; at most one read is outstanding.
REQ-020 A returning response is pushed at the tail with pc4 = issuing PC + 4, unless killed.
REQ-021 Handshake: a pop occurs iff out_valid and out_ready; out_instr/out_pc4 stay stable while out_valid=1 and out_ready=0.
REQ-022 Push and pop in the same cycle leave count unchanged; head and tail pointers wrap modulo DEPTH.
REQ-023 Credit rule (REQ-017) guarantees a push never meets a full queue; no overflow path exists.
REQ-024 On redirect: PC <= target, queue flushed (count=0, pointers=0), the in-flight response in the following cycle is discarded, no issue that cycle; a pop in the same cycle is ignored.
REQ-025 Earliest visibility after redirect: issue at cycle r+1, out_valid at cycle r+3.
REQ-026 Steady state with out_ready=1: one instruction delivered per cycle after fill.

Reset
REQ-027 While rst=1: PC=RESET_PC, count=0, pointers=0, inflight=0, imem_rd=0, out_valid=0.
REQ-028 Reset overrides redirect and handshake; a response arriving the cycle after reset deasserts is discarded.
REQ-029 Data storage is not reset; out_instr/out_pc4 are don't-care while out_valid=0.

Configuration
REQ-030 Macro FETCH_QUEUE_PERF_EN defined: add outputs perf_fetched (32) and perf_flushed (32); perf_fetched increments per pop, perf_flushed adds the number of entries plus in-flight discarded per redirect; both saturate at all-ones and reset to 0.
REQ-031 Macro undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-032 Reset then out_ready=1, sequential fetch from RESET_PC=0 -> imem_addr 0,4,8,...; out_pc4 4,8,12,...; one instruction per cycle after fill.
REQ-033 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 issues, imem_rd held 0 afterward, out_instr stable; release -> in-order drain.
REQ-034 pc_src=01, branch_adr=0x100 while queue holds 3 entries and a read in flight -> queue empty next cycle, stale response dropped, next imem_addr=0x100, first out_pc4=0x104.
REQ-035 pc_src=10, jump_adr=0x40 coincident with a pop -> pop ignored, the next delivered instruction comes from 0x40.
REQ-036 PC=0xFFFFFFFC, XLEN=32 -> next imem_addr=0x00000000, out_pc4 for that instruction = 0x00000000.
REQ-037 rst asserted mid-stream with 2 queued entries and a read in flight -> out_valid=0 next cycle, the next issue reads RESET_PC, no stale instruction delivered.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : PC generator with a credit-limited instruction queue feeding decode.
//            Optional perf counters are enabled by defining FETCH_QUEUE_PERF_EN.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] branch_adr,
    input  logic [XLEN-1:0] jump_adr,
    output logic            imem_rd,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc4
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0]       c_pc_src_branch = 2'b01;
    localparam logic [1:0]       c_pc_src_jump   = 2'b10;
    localparam logic [CNT_W:0]   c_depth         = (CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  issue_pc4_q, issue_pc4_d;

    logic [XLEN-1:0]  instr_mem_q [DEPTH];
    logic [XLEN-1:0]  pc4_mem_q   [DEPTH];

    logic             w_redirect;
    logic [XLEN-1:0]  w_target;
    logic             w_credit;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [XLEN-1:0]  w_pc_plus4;

    // Entries already queued plus the read in flight must leave room for its data.
    assign w_redirect = (pc_src == c_pc_src_branch) || (pc_src == c_pc_src_jump);
    assign w_target   = (pc_src == c_pc_src_branch) ? branch_adr : jump_adr;
    assign w_credit   = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < c_depth;
    assign w_issue    = !rst && !w_redirect && w_credit;
    assign w_push     = inflight_q && !w_redirect;
    assign w_pop      = out_valid && out_ready && !w_redirect;
    assign w_pc_plus4 = pc_q + XLEN'(4);

    assign imem_rd   = w_issue;
    assign imem_addr = pc_q;
    assign out_valid = !rst && (count_q != '0);
    assign out_instr = instr_mem_q[head_q];
    assign out_pc4   = pc4_mem_q[head_q];

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        inflight_d  = w_issue;
        issue_pc4_d = issue_pc4_q;

        if (w_redirect) begin
            pc_d    = w_target;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (w_issue) begin
                pc_d        = w_pc_plus4;
                issue_pc4_d = w_pc_plus4;
            end
            if (w_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (w_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            inflight_q  <= 1'b0;
            issue_pc4_q <= '0;
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            inflight_q  <= inflight_d;
            issue_pc4_q <= issue_pc4_d;
        end
    end

    // Queue storage is deliberately left unreset; out_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            instr_mem_q[tail_q] <= imem_data;
            pc4_mem_q[tail_q]   <= issue_pc4_q;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [32:0] w_flush_sum;

    assign w_flush_sum = {1'b0, perf_flushed_q} + 33'(count_q) + 33'(inflight_q);

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (w_pop && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (w_redirect) begin
            perf_flushed_d = w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Scoreboard bench for fetch_queue with an event-level fetch model.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          N_CYC    = 1500;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] branch_adr;
    logic [31:0] jump_adr;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_src     (pc_src),
        .branch_adr (branch_adr),
        .jump_adr   (jump_adr),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc4    (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] sw;
        sw = {a[15:0], a[31:16]};
        return sw ^ 32'h5A5A_C3C3;
    endfunction

    // Instruction memory: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem_word(imem_addr);
        else         imem_data <= $urandom;
    end

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: model counts fetches outstanding since the last flush.
    initial begin
        logic [31:0] m_pc;
        int          m_out;
        int          m_infl;
        logic        redir, exp_rd, exp_valid, pop;
        logic [31:0] epc;
        m_pc   = RESET_PC;
        m_out  = 0;
        m_infl = 0;
        forever begin
            @(negedge clk);
            redir     = (pc_src == 2'b01) || (pc_src == 2'b10);
            exp_rd    = !rst && !redir && (m_out < DEPTH);
            exp_valid = !rst && ((m_out - m_infl) > 0);
            pop       = exp_valid && out_ready && !redir;

            chk("imem_rd", 32'(imem_rd), 32'(exp_rd));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_rd) chk("imem_addr", imem_addr, m_pc);
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    epc = exp_q.pop_front();
                    chk("out_instr", out_instr, mem_word(epc));
                    chk("out_pc4", out_pc4, epc + 32'd4);
                end
            end

            if (rst) begin
                m_pc = RESET_PC; m_out = 0; m_infl = 0;
            end else if (redir) begin
                m_pc = (pc_src == 2'b01) ? branch_adr : jump_adr;
                m_out = 0; m_infl = 0;
            end else begin
                if (exp_rd) m_pc = m_pc + 32'd4;
                m_out  = m_out + (exp_rd ? 1 : 0) - (pop ? 1 : 0);
                m_infl = exp_rd ? 1 : 0;
            end
        end
    end

    // Stimulus: drives inputs and pushes the expected delivery stream.
    initial begin
        logic [31:0] stream_pc;
        logic [31:0] tgt;
        logic [31:0] targets [6];
        int          rnd;
        int          k;
        targets[0] = 32'h0000_0100;
        targets[1] = 32'h0000_0040;
        targets[2] = 32'hFFFF_FFFC;
        targets[3] = 32'hFFFF_FFF0;
        targets[4] = 32'h0000_1000;
        targets[5] = 32'h8000_0000;
        stream_pc  = RESET_PC;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            rst        = 1'b0;
            pc_src     = 2'b00;
            branch_adr = $urandom;
            jump_adr   = $urandom;
            out_ready  = 1'b1;
            if (cyc < 3) begin
                rst = 1'b1;
            end else if (cyc == 30) begin
                pc_src = 2'b10; jump_adr = 32'h0000_0040;
            end else if (cyc >= 41 && cyc < 51) begin
                out_ready = 1'b0;
            end else if (cyc == 51) begin
                pc_src = 2'b01; branch_adr = 32'h0000_0100; out_ready = 1'b0;
            end else if (cyc == 60) begin
                out_ready = 1'b0;
            end else if (cyc == 61) begin
                rst = 1'b1;
            end else if (cyc == 70) begin
                pc_src = 2'b10; jump_adr = 32'hFFFF_FFF8;
            end else if (cyc >= 90) begin
                rnd       = $urandom_range(0, 99);
                out_ready = ($urandom_range(0, 9) < 7);
                if (rnd < 2) begin
                    rst = 1'b1;
                end else if (rnd < 10) begin
                    k = $urandom_range(0, 6);
                    if (k < 6) begin
                        tgt = targets[k];
                    end else begin
                        tgt = $urandom;
                        tgt[1:0] = 2'b00;
                    end
                    if ($urandom_range(0, 1) == 1) begin
                        pc_src = 2'b01; branch_adr = tgt;
                    end else begin
                        pc_src = 2'b10; jump_adr = tgt;
                    end
                end else if (rnd < 15) begin
                    pc_src = 2'b11;
                end
            end

            if (rst) begin
                exp_q.delete(); stream_pc = RESET_PC;
            end else if (pc_src == 2'b01) begin
                exp_q.delete(); stream_pc = branch_adr;
            end else if (pc_src == 2'b10) begin
                exp_q.delete(); stream_pc = jump_adr;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back(stream_pc);
                stream_pc = stream_pc + 32'd4;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
